// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// NOP           : word returned by the instruction memory for out-of-range addresses.
// fetch_entry_t : one fetched word together with the PC it was fetched from.
package cpu_pkg;

    localparam logic [31:0] NOP = 32'h21000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched words sitting between fetch and decode.
// Ports:
//   clk, reset      : clock and synchronous active-high reset (clears pointers, count and storage)
//   flush           : empties the buffer (pointers and count back to 0)
//   push, wr_entry  : enqueue wr_entry; caller only pushes when !full or when popping
//   pop             : dequeue the head; caller only pops when !empty
//   rd_entry        : current head entry (don't-care while empty)
//   full, empty     : occupancy flags
// DEPTH must be >= 2 and a power of two so the pointers wrap naturally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign rd_entry = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the head reads as zero straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= wr_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Word-addressed instruction memory with a combinational read port.
// Ports:
//   clk                        : clock for the load port
//   addr, instr                : combinational read; out-of-range addresses return NOP
//   wr_en, wr_addr, wr_data    : synchronous load port used to fill the program
module instr_mem
    import cpu_pkg::*;
#(
    parameter int NUM_WORDS = 1024
) (
    input  logic        clk,
    input  logic [31:0] addr,
    output logic [31:0] instr,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int AW = $clog2(NUM_WORDS);

    logic [31:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < 32'(NUM_WORDS))) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign instr = (addr < 32'(NUM_WORDS)) ? mem[addr[AW-1:0]] : NOP;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, addresses the instruction memory and buffers
// fetched {pc, instr} words for decode over a valid/ready handshake.
// Ports:
//   clk, reset                  : clock and synchronous active-high reset
//   imem_addr / imem_instr      : word address out (always the PC), instruction word back (same cycle)
//   halt                        : stop fetching new words; buffered words still drain
//   redirect_valid, redirect_pc : branch/jump target; flushes the buffer and reloads the PC
//   out_valid, out_ready        : handshake to decode
//   out_pc, out_instr           : head word and its PC
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0]  pc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign imem_addr = pc;
    assign out_valid = !empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    assign pop = out_valid && out_ready;
    // A full buffer may still accept a word when the head leaves in the same cycle.
    assign push = !halt && !redirect_valid && (!full || pop);

    assign wr_entry = '{pc: pc, instr: imem_instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + 32'd1;
        end
    end

    // Redirect doubles as the flush; a coinciding pop is still seen by decode.
    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam int          DEPTH     = 2;
    localparam int          NUM_WORDS = 1024;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        mem_wr_en = 1'b0;
    logic [31:0] mem_wr_addr = '0;
    logic [31:0] mem_wr_data = '0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    instr_mem #(
        .NUM_WORDS(NUM_WORDS)
    ) u_mem (
        .clk     (clk),
        .addr    (imem_addr),
        .instr   (imem_instr),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Reference program image and behavioural fetch model.
    logic [31:0]  mm [NUM_WORDS];
    fetch_entry_t q[$];
    logic [31:0]  mpc;
    bit           m_pop;
    bit           m_push;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a < 32'(NUM_WORDS)) return mm[a[9:0]];
        return NOP;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_head(string name, logic [31:0] epc, logic [31:0] einstr);
        check32({name, ".valid"}, {31'b0, out_valid}, 32'd1);
        check32({name, ".pc"}, out_pc, epc);
        check32({name, ".instr"}, out_instr, einstr);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: a queue of {pc, instr}; decode takes the head when ready, fetch
    // appends one word per cycle when allowed, redirect empties the queue.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            mpc = RESET_PC;
        end else begin
            m_pop = (q.size() > 0) && out_ready;
            if (redirect_valid) begin
                q.delete();
                mpc = redirect_pc;
            end else begin
                m_push = !halt && ((q.size() < DEPTH) || m_pop);
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    q.push_back('{pc: mpc, instr: mem_word(mpc)});
                    mpc = mpc + 32'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check32("model.out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                check32("model.out_pc", out_pc, q[0].pc);
                check32("model.out_instr", out_instr, q[0].instr);
            end
            check32("model.imem_addr", imem_addr, mpc);
        end
    end

    initial begin
        // Program load while reset is held.
        for (int i = 0; i < NUM_WORDS; i++) begin
            @(negedge clk);
            mem_wr_en   = 1'b1;
            mem_wr_addr = i;
            mem_wr_data = (i < 5) ? (32'h100 + i) : $urandom;
            mm[i]       = mem_wr_data;
        end
        @(negedge clk);
        mem_wr_en = 1'b0;
        @(negedge clk);
        checking = 1'b1;

        // Reset state.
        check32("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst.out_pc", out_pc, 32'd0);
        check32("rst.out_instr", out_instr, 32'd0);
        check32("rst.imem_addr", imem_addr, RESET_PC);

        // Streaming from reset: one word per cycle.
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_head("stream", k, 32'h100 + k);
        end

        // Backpressure: buffer fills, PC holds, head stable.
        out_ready = 1'b0;
        repeat (5) tick();
        expect_head("stall", 32'd4, 32'h104);
        check32("stall.imem_addr", imem_addr, 32'd6);
        out_ready = 1'b1;
        tick();
        expect_head("resume5", 32'd5, mm[5]);
        tick();
        expect_head("resume6", 32'd6, mm[6]);

        // Redirect while full with a coinciding pop.
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check32("redir.out_valid", {31'b0, out_valid}, 32'd0);
        check32("redir.imem_addr", imem_addr, 32'h40);
        tick();
        expect_head("redir.target", 32'h40, mm[32'h40]);

        // Running off the end of memory yields NOPs.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1023;
        tick();
        redirect_valid = 1'b0;
        tick();
        expect_head("edge1023", 32'd1023, mm[1023]);
        tick();
        expect_head("edge1024", 32'd1024, NOP);
        tick();
        expect_head("edge1025", 32'd1025, NOP);

        // PC wraps at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        expect_head("wrap.top", 32'hFFFF_FFFF, NOP);
        tick();
        expect_head("wrap.zero", 32'd0, 32'h100);

        // Halt with a redirect in its second cycle.
        halt = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        halt = 1'b0;
        check32("halt.out_valid", {31'b0, out_valid}, 32'd0);
        check32("halt.imem_addr", imem_addr, 32'h10);
        tick();
        expect_head("halt.resume", 32'h10, mm[32'h10]);

        // Reset mid-stream with a full buffer.
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check32("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        check32("midrst.imem_addr", imem_addr, RESET_PC);
        out_ready = 1'b1;
        tick();
        expect_head("midrst.restart", RESET_PC, mm[RESET_PC[9:0]]);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom_range(0, 1100);
                1:       redirect_pc = 32'hFFFF_FFFE;
                2:       redirect_pc = $urandom_range(1000, 1023);
                default: redirect_pc = $urandom_range(0, 63);
            endcase
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        tick();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
